// File: rtl/rc_multicast_fork.sv
// Multicast fork: accepts one flit and emits one copy per output direction whose
// mask overlaps the destination bitmap. Copies go out in ascending port order.
module rc_multicast_fork #(
  parameter int unsigned DATASIZE = 30,
  parameter int unsigned DST_LSB  = 9,
  parameter int unsigned DST_W    = 16,
  parameter int unsigned NPORT    = 5,
  parameter logic [NPORT*DST_W-1:0] PORT_MASK =
    {16'h00E0, 16'h0000, 16'hFF00, 16'h000F, 16'h0010}
) (
  input  logic                rc_clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATASIZE-1:0] out_data,
  output logic [NPORT-1:0]    out_dir,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  typedef enum logic {IDLE = 1'b0, FORK = 1'b1} state_t;

  state_t              state;
  logic [DATASIZE-1:0] flit_q;
  logic [NPORT-1:0]    pending;

  logic [DST_W-1:0]    in_dst;
  logic [NPORT-1:0]    acc_pend;
  logic [NPORT-1:0]    src_pend;
  logic [DATASIZE-1:0] src_flit;
  logic [NPORT-1:0]    sel_oh;
  logic [DST_W-1:0]    sel_mask;
  logic [DATASIZE-1:0] fork_data;
  logic                found;

  assign in_ready  = (state == IDLE);
  assign busy      = ~in_ready;
  assign out_valid = (state == FORK);
  assign in_dst    = in_data[DST_LSB +: DST_W];

  always_comb begin
    acc_pend = '0;
    for (int unsigned p = 0; p < NPORT; p++)
      acc_pend[p] = |(in_dst & PORT_MASK[p*DST_W +: DST_W]);
  end

  // The next copy is computed from the incoming flit when idle, or from the
  // pending set minus the copy being handed off, so output regs load directly.
  always_comb begin
    src_pend  = (state == IDLE) ? acc_pend : (pending & ~out_dir);
    src_flit  = (state == IDLE) ? in_data : flit_q;
    sel_oh    = '0;
    sel_mask  = '0;
    found     = 1'b0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (src_pend[p] && !found) begin
        sel_oh[p] = 1'b1;
        sel_mask  = PORT_MASK[p*DST_W +: DST_W];
        found     = 1'b1;
      end
    end
    fork_data                    = src_flit;
    fork_data[DST_LSB +: DST_W]  = src_flit[DST_LSB +: DST_W] & sel_mask;
    fork_data[0]                 = 1'b1;
  end

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      flit_q   <= '0;
      pending  <= '0;
      out_data <= '0;
      out_dir  <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            flit_q  <= in_data;
            pending <= acc_pend;
            if (acc_pend == '0) begin
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
            end else begin
              state    <= FORK;
              out_data <= fork_data;
              out_dir  <= sel_oh;
            end
          end
        end
        FORK: begin
          if (out_ready) begin
            pending <= src_pend;
            if (src_pend == '0) begin
              state <= IDLE;
            end else begin
              out_data <= fork_data;
              out_dir  <= sel_oh;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc_multicast_fork.sv
// Directed and randomized bench for rc_multicast_fork with a copy-list reference model.
module tb_rc_multicast_fork;

  localparam int unsigned DATASIZE = 30;
  localparam int unsigned DST_LSB  = 9;
  localparam int unsigned DST_W    = 16;
  localparam int unsigned NPORT    = 5;
  localparam logic [NPORT*DST_W-1:0] MASKS =
    {16'h00E0, 16'h0000, 16'hFF00, 16'h000F, 16'h0010};

  typedef struct {
    logic [NPORT-1:0]    dir;
    logic [DATASIZE-1:0] data;
  } copy_t;

  logic                rc_clk = 1'b0;
  logic                rst_n;
  logic [DATASIZE-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [DATASIZE-1:0] out_data;
  logic [NPORT-1:0]    out_dir;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic [7:0]          drop_cnt;

  int    checks   = 0;
  int    failures = 0;
  int    exp_drop = 0;
  copy_t exp_q[$];
  copy_t last_copy;

  rc_multicast_fork #(
    .DATASIZE (DATASIZE),
    .DST_LSB  (DST_LSB),
    .DST_W    (DST_W),
    .NPORT    (NPORT),
    .PORT_MASK(MASKS)
  ) dut (
    .rc_clk   (rc_clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_dir  (out_dir),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 rc_clk = ~rc_clk;

  task automatic tick();
    @(posedge rc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATASIZE-1:0] make_flit(input logic [DST_W-1:0] dst);
    logic [DATASIZE-1:0] f;
    f = DATASIZE'($urandom);
    f[DST_LSB +: DST_W] = dst;
    return f;
  endfunction

  // Reference: one copy per port whose mask overlaps dst, ascending port order.
  task automatic build_expected(input logic [DATASIZE-1:0] flit);
    logic [DST_W-1:0] dst, m;
    copy_t c;
    exp_q.delete();
    dst = flit[DST_LSB +: DST_W];
    for (int p = 0; p < int'(NPORT); p++) begin
      m = MASKS[p*DST_W +: DST_W];
      if ((dst & m) != '0) begin
        c.dir  = NPORT'(1) << p;
        c.data = flit;
        c.data[DST_LSB +: DST_W] = dst & m;
        c.data[0] = 1'b1;
        exp_q.push_back(c);
      end
    end
  endtask

  // mode 0: out_ready always 1; mode 1: low for 4 cycles then 1; mode 2: random
  task automatic send(input logic [DATASIZE-1:0] flit, input int mode);
    int guard;
    int cyc;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_before_send", in_ready, 1'b1);
    in_data  = flit;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = DATASIZE'($urandom);
    build_expected(flit);
    if (exp_q.size() == 0) begin
      if (exp_drop < 255) exp_drop++;
      check("drop_no_valid", out_valid, 1'b0);
      check("drop_cnt", drop_cnt, exp_drop);
      check("drop_in_ready", in_ready, 1'b1);
    end else begin
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc >= 4);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        in_valid = 1'($urandom_range(0, 1));
        check("fork_out_valid", out_valid, 1'b1);
        check("fork_in_ready", in_ready, 1'b0);
        check("fork_busy", busy, 1'b1);
        check("fork_out_dir", out_dir, exp_q[0].dir);
        check("fork_out_data", out_data, exp_q[0].data);
        tick();
        in_valid = 1'b0;
        cyc++;
        if (out_ready) begin
          last_copy = exp_q[0];
          void'(exp_q.pop_front());
        end
      end
      check("copies_outstanding", exp_q.size(), 0);
      check("done_in_ready", in_ready, 1'b1);
      check("done_out_valid", out_valid, 1'b0);
      check("idle_hold_dir", out_dir, last_copy.dir);
      check("idle_hold_data", out_data, last_copy.data);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    logic [DATASIZE-1:0] f;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    check("rst_out_data", out_data, '0);
    check("rst_out_dir", out_dir, '0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // Fork order, full-rate drain
    send(make_flit(16'hFF1F), 0);
    // Backpressure on first copy
    send(make_flit(16'hFF1F), 1);
    // Drop path and saturation
    send(make_flit(16'h0000), 0);
    check("drop_first", drop_cnt, 8'd1);
    for (int i = 0; i < 299; i++) send(make_flit(16'h0000), 0);
    check("drop_saturated", drop_cnt, 8'd255);
    // Sparse single copies back to back
    send(make_flit(16'h0040), 0);
    send(make_flit(16'h0040), 0);
    // Uncovered destination bits only
    send(make_flit(16'h0000), 0);

    // Reset in the middle of a fork
    f = make_flit(16'hFF1F);
    build_expected(f);
    in_data = f; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid_first_dir", out_dir, exp_q[0].dir);
    check("mid_first_data", out_data, exp_q[0].data);
    tick();
    check("mid_second_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, '0);
    check("mid_rst_dir", out_dir, '0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_drop", drop_cnt, 8'd0);
    exp_drop = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_abort_no_valid", out_valid, 1'b0);
      check("post_abort_in_ready", in_ready, 1'b1);
    end

    // Randomized traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       send(make_flit(16'h0000), 2);
        1:       send(make_flit(DST_W'(16'h0001 << $urandom_range(0, 15))), 2);
        default: send(make_flit(DST_W'($urandom)), 2);
      endcase
    end
    check("final_drop_cnt", drop_cnt, exp_drop);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rc_multicast_fork.md
RC_MULTICAST_FORK -- requirements
Module: rc_multicast_fork

Interface
REQ-001 Parameter DATASIZE, default 30, flit width in bits.
REQ-002 Parameter DST_LSB, default 9, LSB position of the destination bitmap within the flit.
REQ-003 Parameter DST_W, default 16, destination bitmap width.
REQ-004 Parameter NPORT, default 5, number of output directions; also the width of out_dir.
REQ-005 Parameter PORT_MASK, default {16'h00E0,16'h0000,16'hFF00,16'h000F,16'h0010}, NPORT*DST_W bits; port p mask is PORT_MASK[p*DST_W +: DST_W].
REQ-006 rc_clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_data  input  DATASIZE  incoming multicast flit.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  block can accept a flit.
REQ-011 out_data  output  DATASIZE  forked copy for one direction.
REQ-012 out_dir  output  NPORT  one-hot direction of out_data.
REQ-013 out_valid  output  1  out_data/out_dir valid.
REQ-014 out_ready  input  1  downstream accepts the copy.
REQ-015 busy  output  1  high while copies are pending.
REQ-016 drop_cnt  output  8  count of flits dropped for having no reachable destination.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and FORK.
REQ-018 in_ready SHALL be 1 exactly when state is IDLE, decoded directly from the state register; busy SHALL be the inverse of in_ready.
REQ-019 Accept = in_valid & in_ready; on accept, the block SHALL register the flit and pending[p] = |(dst & mask_p) for every p, where dst = in_data[DST_LSB +: DST_W].
REQ-020 Accept with pending all-zero: state stays IDLE, no output, drop_cnt increments, saturating at 255.
REQ-021 Accept with pending non-zero: state goes to FORK on the next edge, so out_valid is high one cycle after accept.
REQ-022 In FORK: out_valid = 1; sel = lowest-index set bit of pending; out_dir = one-hot(sel).
REQ-023 out_data SHALL be the stored flit with dst field replaced by dst & mask_sel, and bit 0 forced to 1; all other bits pass unchanged.
REQ-024 While out_valid & !out_ready, out_data, out_dir and pending SHALL hold stable.
REQ-025 On out_valid & out_ready: clear pending[sel]; if that was the last set bit, return to IDLE on the same edge, else present the next port on the following cycle.
REQ-026 Each port SHALL be emitted at most once per flit, in ascending port order; ports with zero sub-bitmap SHALL be skipped without any idle cycle.
REQ-027 In IDLE: out_valid = 0; out_data and out_dir SHALL hold their last values.
REQ-028 Destination bits not covered by any mask SHALL be discarded silently.
REQ-029 in_valid while in FORK SHALL be ignored; the upstream holds the flit because in_ready is 0.
REQ-030 Minimum per-flit occupancy SHALL be 1 + k cycles for k copies with out_ready held at 1.

Reset
REQ-031 When rst_n = 0, regardless of clock, the block SHALL reset: state to IDLE, pending to 0, stored flit to 0, out_data to 0, out_dir to 0, out_valid to 0, drop_cnt to 0.
REQ-032 in_ready SHALL be 1 and busy 0 while in reset and immediately after release.
REQ-033 Reset asserted in FORK SHALL abort all pending copies; no copy is emitted after release.

Verification
REQ-034 Fork order: dst = 16'hFF1F, out_ready = 1 -> three copies on consecutive cycles, out_dir 00001 (dst 0010), then 00010 (dst 000F), then 00100 (dst FF00); then in_ready = 1.
REQ-035 Backpressure: same flit, out_ready = 0 for 4 cycles, then 1 -> copy 00001 held stable for 5 cycles, remaining copies follow, in_ready stays 0 throughout.
REQ-036 Drop: dst = 16'h0000 -> no out_valid, drop_cnt = 1, in_ready remains 1; 300 such flits -> drop_cnt = 255.
REQ-037 Sparse single: dst = 16'h0040 -> one copy, out_dir 10000, dst field 0040, bit 0 = 1; back-to-back second flit accepted 2 cycles after the first.
REQ-038 Reset mid-fork: dst = 16'hFF1F, assert rst_n = 0 after the first copy -> out_valid = 0 at once, no further copies, all outputs 0, in_ready = 1.
